// File: rtl/burst_rom_reader.sv
`default_nettype none
// ============================================================================
//  Module   : burst_rom_reader
//  Purpose  : Parametrised ROM with a registered read path that serves burst
//             reads. A burst (start address + length) is accepted on a
//             valid/ready request channel. The words are streamed out on a
//             valid/ready response channel. The address auto-increments and
//             wraps modulo DEPTH, and the output is held under backpressure.
//  Revision : 1.0 - initial release, replaces the fixed 4x4 combinational ROM
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       single clock, rising edge
//    rst_n      in   1       asynchronous active-low reset
//    req_valid  in   1       burst request valid
//    req_ready  out  1       request accepted (high only while idle)
//    req_addr   in   ADDR_W  burst start address
//    req_len    in   LEN_W   beats in burst minus one
//    rsp_valid  out  1       rsp_data holds a valid beat
//    rsp_ready  in   1       consumer takes the current beat
//    rsp_data   out  DATA_W  ROM word
//    rsp_last   out  1       final beat of the burst
//    busy       out  1       burst in progress
// ============================================================================
module burst_rom_reader #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 2,
    parameter int LEN_W     = 4,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // ------------------------------------------------------------------
    // ROM contents, fixed at elaboration
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        // The cast truncates to DATA_W bits, which is the mod 2**DATA_W
        assign w_rom[i] = DATA_W'(5 * i + 3);
    end

    // ------------------------------------------------------------------
    // Burst engine
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0] w_next_addr;

    // ADDR_W-bit add: wraps from DEPTH-1 back to 0
    assign w_next_addr = r_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_remaining <= req_len;
                        r_rsp_data  <= w_rom[req_addr];
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= (req_len == '0);
                        r_state     <= c_ST_BURST;
                    end
                end
                c_ST_BURST: begin
                    // Without a handshake everything holds, so a stalled beat
                    // is neither lost nor repeated
                    if (r_rsp_valid && rsp_ready) begin
                        if (r_rsp_last) begin
                            r_rsp_valid <= 1'b0;
                            r_rsp_last  <= 1'b0;
                            r_state     <= c_ST_IDLE;
                        end else begin
                            r_addr      <= w_next_addr;
                            r_rsp_data  <= w_rom[w_next_addr];
                            r_remaining <= r_remaining - LEN_W'(1);
                            r_rsp_last  <= (r_remaining == LEN_W'(1));
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state == c_ST_BURST);
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
